// File: rtl/demux_1x2_nibble.sv
// rtl/demux_1x2_nibble.sv - 1:2 nibble demultiplexer with valid/ready input and pair hold
//
// Splits a serial stream of ANCHO-bit nibbles into pairs: the first nibble
// of each pair lands in Y0, the second in Y1, and the pair is held
// (Par_valido=1, Listo=0) until the consumer acknowledges with Par_tomado.
//
// Optional feature macro: DEMUX_TIMEOUT_EN
//   defined   : a half pair waiting in ESPERA_D1 is abandoned after
//               TIMEOUT_CICLOS cycles without a second nibble (Error_timeout pulse)
//   undefined : ESPERA_D1 waits indefinitely, Error_timeout tied low
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous reset, active high
//   Dato          incoming nibble
//   Dato_valido   Dato is valid this cycle
//   Listo         block can accept Dato this cycle (combinational from state)
//   Y0            lane 0 register (first nibble of pair)
//   Y1            lane 1 register (second nibble of pair)
//   Seleccion     lane the next accepted nibble goes to (0 = Y0, 1 = Y1)
//   Par_valido    Y1/Y0 hold a complete pair
//   Par_tomado    consumer acknowledge, honoured only while Par_valido=1
//   Desborde      one-cycle pulse: a nibble was offered while Listo=0 and dropped
//   Error_timeout one-cycle pulse: half pair abandoned

module demux_1x2_nibble #(
  parameter int ANCHO          = 4,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] Dato,
  input  logic             Dato_valido,
  output logic             Listo,
  output logic [ANCHO-1:0] Y0,
  output logic [ANCHO-1:0] Y1,
  output logic             Seleccion,
  output logic             Par_valido,
  input  logic             Par_tomado,
  output logic             Desborde,
  output logic             Error_timeout
);

  typedef enum logic [1:0] {
    ESPERA_D0 = 2'd0,
    ESPERA_D1 = 2'd1,
    LLENO     = 2'd2
  } estado_t;

  estado_t estado, estado_sig;
  logic    acepta;
  logic    timeout;

  // Handshake and status outputs are decoded straight from the state
  // register, so none of them has a path from Dato/Dato_valido.
  assign Listo      = (estado != LLENO);
  assign acepta     = Dato_valido && Listo;
  // Lane 1 stays selected while the pair is held; it drops back to lane 0
  // together with the acknowledge.
  assign Seleccion  = (estado != ESPERA_D0);
  assign Par_valido = (estado == LLENO);

`ifdef DEMUX_TIMEOUT_EN
  localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);

  logic [15:0] cuenta;

  // An accept in the limit cycle completes the pair instead of timing out.
  assign timeout = (estado == ESPERA_D1) && !acepta && (cuenta == LIMITE);

  // Held at zero outside ESPERA_D1, so every entry into ESPERA_D1 starts
  // counting from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
    end else if (estado != ESPERA_D1 || acepta) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + 16'd1;
    end
  end
`else
  logic unused_timeout_ciclos;
  assign unused_timeout_ciclos = ^TIMEOUT_CICLOS;
  assign timeout = 1'b0;
`endif

  always_comb begin
    estado_sig = estado;
    case (estado)
      ESPERA_D0: if (acepta) estado_sig = ESPERA_D1;
      ESPERA_D1: begin
        if (acepta) begin
          estado_sig = LLENO;
        end else if (timeout) begin
          estado_sig = ESPERA_D0;
        end
      end
      LLENO:     if (Par_tomado) estado_sig = ESPERA_D0;
      default:   estado_sig = ESPERA_D0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= ESPERA_D0;
      Y0            <= '0;
      Y1            <= '0;
      Desborde      <= 1'b0;
      Error_timeout <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (acepta && estado == ESPERA_D0) begin
        Y0 <= Dato;
      end
      if (acepta && estado == ESPERA_D1) begin
        Y1 <= Dato;
      end
      Desborde      <= Dato_valido && !Listo;
      Error_timeout <= timeout;
    end
  end

endmodule

// File: tb/tb_demux_1x2_nibble.sv
// tb/tb_demux_1x2_nibble.sv - self-checking bench for demux_1x2_nibble

module tb_demux_1x2_nibble;

  localparam int ANCHO = 4;
  localparam int TOUT  = 4;
`ifdef DEMUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ANCHO-1:0] Dato = '0;
  logic             Dato_valido = 1'b0;
  logic             Listo;
  logic [ANCHO-1:0] Y0, Y1;
  logic             Seleccion, Par_valido;
  logic             Par_tomado = 1'b0;
  logic             Desborde, Error_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: how many nibbles of the current pair are held
  // (0, 1 or 2), the two lane values, idle cycles spent on a half pair,
  // and the pulses expected after the most recent edge.
  logic [ANCHO-1:0] m_y0, m_y1;
  int               m_n, m_idle;
  bit               m_desb, m_err;

  demux_1x2_nibble #(.ANCHO(ANCHO), .TIMEOUT_CICLOS(TOUT)) dut (
    .clk(clk), .reset(reset), .Dato(Dato), .Dato_valido(Dato_valido),
    .Listo(Listo), .Y0(Y0), .Y1(Y1), .Seleccion(Seleccion),
    .Par_valido(Par_valido), .Par_tomado(Par_tomado),
    .Desborde(Desborde), .Error_timeout(Error_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_y0 = '0; m_y1 = '0; m_n = 0; m_idle = 0; m_desb = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [ANCHO-1:0] d, input bit t);
    bit ready;
    ready  = (m_n != 2);
    m_desb = v && !ready;
    m_err  = 0;
    if (m_n == 2) begin
      if (t) m_n = 0;
    end else if (v) begin
      if (m_n == 0) begin
        m_y0 = d; m_n = 1; m_idle = 0;
      end else begin
        m_y1 = d; m_n = 2;
      end
    end else if (m_n == 1 && TO_EN) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_n = 0; m_err = 1;
      end
    end
  endtask

  // One clock cycle: inputs applied 1 time unit after an edge, outputs
  // observed 1 time unit after the following edge.
  task automatic step(input bit v, input logic [ANCHO-1:0] d, input bit t);
    reset = 1'b0; Dato_valido = v; Dato = d; Par_tomado = t;
    model_step(v, d, t);
    @(posedge clk); #1;
    Dato_valido = 1'b0; Par_tomado = 1'b0;
  endtask

  task automatic step_reset();
    reset = 1'b1; Dato_valido = 1'b0; Par_tomado = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step_reset();
    step_reset();
    n_cmp++; if (Y0 !== 4'h0) begin n_bad++; $display("FAIL reset_y0 got %h want 0", Y0); end
    n_cmp++; if (Y1 !== 4'h0) begin n_bad++; $display("FAIL reset_y1 got %h want 0", Y1); end
    n_cmp++; if ({Seleccion, Par_valido, Desborde, Error_timeout} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {Seleccion, Par_valido, Desborde, Error_timeout});
    end
    n_cmp++; if (Listo !== 1'b1) begin n_bad++; $display("FAIL reset_listo got %b want 1", Listo); end
  endtask

  task automatic test_pair();
    step(1, 4'h3, 0);
    n_cmp++; if (Seleccion !== 1'b1) begin n_bad++; $display("FAIL pair_sel1 got %b want 1", Seleccion); end
    n_cmp++; if (Par_valido !== 1'b0) begin n_bad++; $display("FAIL pair_early_valid got %b want 0", Par_valido); end
    step(1, 4'hA, 0);
    n_cmp++; if (Y0 !== 4'h3) begin n_bad++; $display("FAIL pair_y0 got %h want 3", Y0); end
    n_cmp++; if (Y1 !== 4'hA) begin n_bad++; $display("FAIL pair_y1 got %h want a", Y1); end
    n_cmp++; if (Par_valido !== 1'b1) begin n_bad++; $display("FAIL pair_valid got %b want 1", Par_valido); end
    n_cmp++; if (Listo !== 1'b0) begin n_bad++; $display("FAIL pair_listo got %b want 0", Listo); end
    n_cmp++; if (Seleccion !== 1'b1) begin n_bad++; $display("FAIL pair_sel2 got %b want 1", Seleccion); end
  endtask

  task automatic test_hold_ack();
    for (int i = 0; i < 5; i++) begin
      step(0, 4'h0, 0);
      n_cmp++; if (Par_valido !== 1'b1 || Y0 !== 4'h3 || Y1 !== 4'hA) begin
        n_bad++; $display("FAIL hold_%0d got valid=%b y0=%h y1=%h want 1 3 a", i, Par_valido, Y0, Y1);
      end
    end
    step(0, 4'h0, 1);
    n_cmp++; if (Par_valido !== 1'b0) begin n_bad++; $display("FAIL ack_valid got %b want 0", Par_valido); end
    n_cmp++; if (Listo !== 1'b1) begin n_bad++; $display("FAIL ack_listo got %b want 1", Listo); end
    n_cmp++; if (Seleccion !== 1'b0) begin n_bad++; $display("FAIL ack_sel got %b want 0", Seleccion); end
    n_cmp++; if (Y0 !== 4'h3 || Y1 !== 4'hA) begin n_bad++; $display("FAIL ack_keep got %h/%h want 3/a", Y0, Y1); end
  endtask

  task automatic test_overflow();
    step(1, 4'h3, 0);
    step(1, 4'hA, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 4'hF, 0);
      n_cmp++; if (Desborde !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse_%0d got %b want 1", i, Desborde); end
      n_cmp++; if (Y0 !== 4'h3 || Y1 !== 4'hA) begin n_bad++; $display("FAIL ovf_keep_%0d got %h/%h want 3/a", i, Y0, Y1); end
    end
    step(0, 4'h0, 0);
    n_cmp++; if (Desborde !== 1'b0) begin n_bad++; $display("FAIL ovf_end got %b want 0", Desborde); end
  endtask

  task automatic test_same_cycle();
    step(1, 4'h7, 1);
    n_cmp++; if (Par_valido !== 1'b0 || Listo !== 1'b1) begin
      n_bad++; $display("FAIL same_state got valid=%b listo=%b want 0 1", Par_valido, Listo);
    end
    n_cmp++; if (Desborde !== 1'b1) begin n_bad++; $display("FAIL same_desb got %b want 1", Desborde); end
    n_cmp++; if (Y0 !== 4'h3 || Y1 !== 4'hA) begin n_bad++; $display("FAIL same_keep got %h/%h want 3/a", Y0, Y1); end
    step(0, 4'h0, 0);
    n_cmp++; if (Desborde !== 1'b0) begin n_bad++; $display("FAIL same_desb_once got %b want 0", Desborde); end
  endtask

  task automatic test_reset_mid();
    step(1, 4'h5, 0);
    step_reset();
    n_cmp++; if ({Y0, Y1, Seleccion, Par_valido, Desborde, Error_timeout} !== '0) begin
      n_bad++; $display("FAIL midreset got y0=%h y1=%h sel=%b pv=%b want all 0", Y0, Y1, Seleccion, Par_valido);
    end
    step(1, 4'h1, 0);
    step(1, 4'h2, 0);
    n_cmp++; if (Y0 !== 4'h1 || Y1 !== 4'h2 || Par_valido !== 1'b1) begin
      n_bad++; $display("FAIL midreset_pair got %h/%h pv=%b want 1/2 1", Y0, Y1, Par_valido);
    end
    step(0, 4'h0, 1);
  endtask

`ifdef DEMUX_TIMEOUT_EN
  task automatic test_timeout();
    step(1, 4'h9, 0);
    for (int i = 0; i < TOUT - 1; i++) begin
      step(0, 4'h0, 0);
      n_cmp++; if (Error_timeout !== 1'b0 || Seleccion !== 1'b1) begin
        n_bad++; $display("FAIL to_wait_%0d got err=%b sel=%b want 0 1", i, Error_timeout, Seleccion);
      end
    end
    step(0, 4'h0, 0);
    n_cmp++; if (Error_timeout !== 1'b1 || Seleccion !== 1'b0 || Par_valido !== 1'b0) begin
      n_bad++; $display("FAIL to_fire got err=%b sel=%b pv=%b want 1 0 0", Error_timeout, Seleccion, Par_valido);
    end
    step(0, 4'h0, 0);
    n_cmp++; if (Error_timeout !== 1'b0) begin n_bad++; $display("FAIL to_once got %b want 0", Error_timeout); end
    step(1, 4'h9, 0);
    for (int i = 0; i < TOUT - 1; i++) step(0, 4'h0, 0);
    step(1, 4'hB, 0);
    n_cmp++; if (Y0 !== 4'h9 || Y1 !== 4'hB || Par_valido !== 1'b1 || Error_timeout !== 1'b0) begin
      n_bad++; $display("FAIL to_race got %h/%h pv=%b err=%b want 9/b 1 0", Y0, Y1, Par_valido, Error_timeout);
    end
    step(0, 4'h0, 1);
  endtask
`endif

  task automatic test_random();
    bit               v, t;
    logic [ANCHO-1:0] d;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        step_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        t = ($urandom_range(0, 2) == 0);
        d = ANCHO'($urandom);
        if ($urandom_range(0, 5) == 0) v = 1'b0;
        step(v, d, t);
      end
      n_cmp++; if (Y0 !== m_y0 || Y1 !== m_y1) begin
        n_bad++; $display("FAIL rnd_y_%0d got %h/%h want %h/%h", i, Y0, Y1, m_y0, m_y1);
      end
      n_cmp++; if (Par_valido !== (m_n == 2) || Listo !== (m_n != 2) || Seleccion !== (m_n != 0)) begin
        n_bad++; $display("FAIL rnd_state_%0d got pv=%b listo=%b sel=%b want n=%0d", i, Par_valido, Listo, Seleccion, m_n);
      end
      n_cmp++; if (Desborde !== m_desb || Error_timeout !== m_err) begin
        n_bad++; $display("FAIL rnd_pulse_%0d got desb=%b err=%b want %b %b", i, Desborde, Error_timeout, m_desb, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pair();
    test_hold_ack();
    test_overflow();
    test_same_cycle();
    test_reset_mid();
`ifdef DEMUX_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
